// File: rtl/serial_sub.sv
// rtl/serial_sub.sv - bit-serial subtractor computing a - b one bit per clock, LSB first
//
// Ports:
//   clk   - clock, all state changes on the rising edge
//   rst   - synchronous active-high reset
//   start - request a subtraction, sampled only while idle
//   a, b  - minuend / subtrahend, captured on the accepting edge
//   busy  - high while bits are being processed
//   done  - one-cycle pulse after the last bit
//   diff  - registered result a - b mod 2^WIDTH
//   bout  - registered final borrow (a < b unsigned)
//   zero  - diff == 0, only with SERIAL_SUB_FLAGS_EN
//   ovf   - two's-complement overflow, only with SERIAL_SUB_FLAGS_EN
module serial_sub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_FLAGS_EN
    output logic             bout,
    output logic             zero,
    output logic             ovf
`else
    output logic             bout
`endif
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             br_q, br_d;
    logic             bout_q, bout_d;

    logic             a0, b0, d_bit, br_next;
    logic [WIDTH-1:0] res_next;

`ifdef SERIAL_SUB_FLAGS_EN
    logic zero_q, zero_d;
    logic ovf_q, ovf_d;
`endif

    // One full-subtractor stage on the current LSBs.
    assign a0       = a_sh_q[0];
    assign b0       = b_sh_q[0];
    assign d_bit    = a0 ^ b0 ^ br_q;
    assign br_next  = (~a0 & b0) | (~(a0 ^ b0) & br_q);
    assign res_next = {d_bit, res_q[WIDTH-1:1]};

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;
        diff_d  = diff_q;
        cnt_d   = cnt_q;
        br_d    = br_q;
        bout_d  = bout_q;
`ifdef SERIAL_SUB_FLAGS_EN
        zero_d  = zero_q;
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    a_sh_d  = a;
                    b_sh_d  = b;
                    res_d   = '0;
                    cnt_d   = '0;
                    br_d    = 1'b0;
                end
            end
            RUN: begin
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                res_d  = res_next;
                br_d   = br_next;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    diff_d  = res_next;
                    bout_d  = br_next;
`ifdef SERIAL_SUB_FLAGS_EN
                    // On the last bit the LSBs are the operand sign bits
                    // and d_bit is the result sign bit.
                    zero_d  = (res_next == '0);
                    ovf_d   = (a0 ^ b0) & (d_bit ^ a0);
`endif
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            diff_q  <= '0;
            cnt_q   <= '0;
            br_q    <= 1'b0;
            bout_q  <= 1'b0;
`ifdef SERIAL_SUB_FLAGS_EN
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            diff_q  <= diff_d;
            cnt_q   <= cnt_d;
            br_q    <= br_d;
            bout_q  <= bout_d;
`ifdef SERIAL_SUB_FLAGS_EN
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign diff = diff_q;
    assign bout = bout_q;
`ifdef SERIAL_SUB_FLAGS_EN
    assign zero = zero_q;
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_sub.sv
// tb/tb_serial_sub.sv - randomized self-checking bench for serial_sub against an arithmetic model
module tb_serial_sub;

    localparam int W = 8;
    localparam int MASK = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a, b;
    logic         busy, done, bout;
    logic [W-1:0] diff;
`ifdef SERIAL_SUB_FLAGS_EN
    logic         zero, ovf;
`endif

    int checks = 0;
    int errors = 0;

    serial_sub #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
`ifdef SERIAL_SUB_FLAGS_EN
        .bout  (bout),
        .zero  (zero),
        .ovf   (ovf)
`else
        .bout  (bout)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are read there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference results, computed with plain integer arithmetic.
    int exp_diff, exp_bout, exp_zero, exp_ovf;

    function automatic int to_signed(input int v);
        return (v >= (1 << (W - 1))) ? v - (1 << W) : v;
    endfunction

    task automatic model(input int av, input int bv);
        int sd;
        exp_diff = (av - bv) & MASK;
        exp_bout = (av < bv) ? 1 : 0;
        exp_zero = (exp_diff == 0) ? 1 : 0;
        sd = to_signed(av) - to_signed(bv);
        exp_ovf  = (sd > (1 << (W - 1)) - 1 || sd < -(1 << (W - 1))) ? 1 : 0;
    endtask

    task automatic check_results(input string tag);
        check({tag, ".diff"}, 32'(diff), 32'(exp_diff));
        check({tag, ".bout"}, 32'(bout), 32'(exp_bout));
`ifdef SERIAL_SUB_FLAGS_EN
        check({tag, ".zero"}, 32'(zero), 32'(exp_zero));
        check({tag, ".ovf"},  32'(ovf),  32'(exp_ovf));
`endif
    endtask

    // Starts an operation from IDLE, disturbs start/a/b during RUN, and checks
    // busy length, done pulse width, result hold and final result.
    task automatic run_op(input int av, input int bv, input string tag);
        int cycles;
        logic [W-1:0] old_diff;
        logic         old_bout;
        old_diff = diff;
        old_bout = bout;
        a = W'(av);
        b = W'(bv);
        start = 1'b1;
        tick();
        model(av, bv);
        cycles = 0;
        while (!done && cycles < 4 * W) begin
            if (busy) cycles++;
            check({tag, ".hold_diff"}, 32'(diff), 32'(old_diff));
            check({tag, ".hold_bout"}, 32'(bout), 32'(old_bout));
            start = 1'($urandom_range(0, 1));
            a = W'($urandom);
            b = W'($urandom);
            tick();
        end
        start = 1'b0;
        check({tag, ".done"}, 32'(done), 32'd1);
        check({tag, ".busy_cycles"}, 32'(cycles), 32'(W));
        check({tag, ".busy_in_done"}, 32'(busy), 32'd0);
        check_results(tag);
        tick();
        check({tag, ".done_pulse"}, 32'(done), 32'd0);
        check({tag, ".idle_busy"}, 32'(busy), 32'd0);
        check_results({tag, ".held"});
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b1;
        a = 8'hAA;
        b = 8'h55;
        tick();
        tick();
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.done", 32'(done), 32'd0);
        check("rst.diff", 32'(diff), 32'd0);
        check("rst.bout", 32'(bout), 32'd0);
`ifdef SERIAL_SUB_FLAGS_EN
        check("rst.zero", 32'(zero), 32'd0);
        check("rst.ovf",  32'(ovf),  32'd0);
`endif
        rst = 1'b0;
        start = 1'b0;
        tick();

        run_op(8'h35, 8'h12, "t35_12");
        run_op(8'h12, 8'h35, "t12_35");
        run_op(8'h00, 8'h01, "t00_01");
        run_op(8'h80, 8'h01, "t80_01");
        run_op(8'h5A, 8'h5A, "t5a_5a");
        run_op(8'h00, 8'hFF, "t00_ff");
        run_op(8'h7F, 8'hFF, "t7f_ff");
        for (int i = 0; i < 30; i++) begin
            run_op(int'($urandom_range(0, MASK)), int'($urandom_range(0, MASK)), "rand");
        end

        // start held high through RUN/DONE restarts only once back in IDLE.
        a = 8'h10;
        b = 8'h01;
        start = 1'b1;
        tick();
        a = 8'hFF;
        b = 8'h00;
        for (int i = 0; i < W; i++) begin
            check("hold.done_in_run", 32'(done), 32'd0);
            tick();
        end
        check("hold.done", 32'(done), 32'd1);
        check("hold.diff", 32'(diff), 32'h0F);
        tick();
        check("hold.idle", 32'(busy | done), 32'd0);
        tick();
        check("hold.restart_busy", 32'(busy), 32'd1);
        start = 1'b0;
        for (int i = 0; i < W; i++) tick();
        check("hold.second_done", 32'(done), 32'd1);
        check("hold.second_diff", 32'(diff), 32'hFF);
        tick();

        // Reset in the middle of RUN aborts with cleared results and no done.
        a = 8'h35;
        b = 8'h12;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort.busy", 32'(busy), 32'd0);
        check("abort.done", 32'(done), 32'd0);
        check("abort.diff", 32'(diff), 32'd0);
        check("abort.bout", 32'(bout), 32'd0);
        begin
            int seen = 0;
            for (int i = 0; i < W + 4; i++) begin
                if (done || busy) seen++;
                tick();
            end
            check("abort.no_done", 32'(seen), 32'd0);
        end

        run_op(8'h35, 8'h12, "after_abort");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
